// File: rtl/lstm_pkg.sv
// lstm_pkg: driver FSM states, default layer sizes, and the step-index width helper
package lstm_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, DRIVE, WAIT, EMIT} drv_state_t;
  localparam int DEF_N           = 8;
  localparam int DEF_INPUT_SIZE  = 128;
  localparam int DEF_HIDDEN_SIZE = 64;
  function automatic int idx_width(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction
endpackage

// File: rtl/lstm_step_timer.sv
// lstm_step_timer: loadable down-counter that flags expiry of the layer latency
module lstm_step_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  assign done = count == '0;
endmodule

// File: rtl/lstm_seq_driver.sv
// lstm_seq_driver: feeds one vector per layer step, clears state at sequence start, returns h_t
module lstm_seq_driver
  import lstm_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int INPUT_SIZE    = DEF_INPUT_SIZE,
  parameter int HIDDEN_SIZE   = DEF_HIDDEN_SIZE,
  parameter int SEQ_LEN       = 16,
  parameter int LAYER_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_SIZE-1:0]         in_data,
  input  logic                          in_last,
  output logic [INPUT_SIZE-1:0]         x_t,
  output logic                          step_en,
  output logic                          layer_clear,
  input  logic [HIDDEN_SIZE-1:0]        h_t,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HIDDEN_SIZE-1:0]        out_data,
  output logic                          out_last,
  output logic [idx_width(SEQ_LEN)-1:0] step_idx
);
  localparam int IW = idx_width(SEQ_LEN);
  localparam int TW = $clog2(LAYER_LATENCY + 1);
  if (INPUT_SIZE % N != 0) begin : g_size_check
    $error("INPUT_SIZE must be a multiple of N");
  end
  drv_state_t state, state_n;
  logic first, last_q, done, accept, fire;
  assign in_ready    = state == IDLE;
  assign layer_clear = state == CLEAR;
  assign step_en     = state == DRIVE;
  assign out_valid   = state == EMIT;
  assign accept      = in_valid & in_ready;
  assign fire        = out_valid & out_ready;
  lstm_step_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (step_en),
    .load_val (TW'(LAYER_LATENCY - 1)),
    .done     (done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (first ? CLEAR : DRIVE) : IDLE;
      CLEAR:   state_n = DRIVE;
      DRIVE:   state_n = WAIT;
      WAIT:    state_n = done ? EMIT : WAIT;
      EMIT:    state_n = out_ready ? IDLE : EMIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      first    <= 1'b1;
      last_q   <= 1'b0;
      x_t      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      step_idx <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        x_t    <= in_data;
        last_q <= in_last | (step_idx == IW'(SEQ_LEN - 1));
      end
      if (layer_clear) first <= 1'b0;
      if (state == WAIT && done) begin
        out_data <= h_t;
        out_last <= last_q;
      end
      if (fire) begin
        step_idx <= last_q ? '0 : step_idx + 1'b1;
        if (last_q) first <= 1'b1;
      end
    end
  end
endmodule
